// File: rtl/exec_reg_file.sv
// rtl/exec_reg_file.sv - per-wavefront EXEC/VCC/M0/SCC state store
module exec_reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_init_wf_en,
    input  logic [5:0]  fetch_init_wf_id,
    input  logic [63:0] fetch_init_value,
    input  logic        salu_wr_exec_en,
    input  logic        salu_wr_vcc_en,
    input  logic        salu_wr_m0_en,
    input  logic        salu_wr_scc_en,
    input  logic [5:0]  salu_wr_wfid,
    input  logic [63:0] salu_wr_exec_value,
    input  logic [63:0] salu_wr_vcc_value,
    input  logic [31:0] salu_wr_m0_value,
    input  logic        salu_wr_scc_value,
    input  logic        salu_rd_en,
    input  logic [5:0]  salu_rd_wfid,
    input  logic        simd0_rd_en,
    input  logic        simd1_rd_en,
    input  logic        simd2_rd_en,
    input  logic        simd3_rd_en,
    input  logic        simf0_rd_en,
    input  logic        simf1_rd_en,
    input  logic        simf2_rd_en,
    input  logic        simf3_rd_en,
    input  logic [5:0]  simd0_rd_wfid,
    input  logic [5:0]  simd1_rd_wfid,
    input  logic [5:0]  simd2_rd_wfid,
    input  logic [5:0]  simd3_rd_wfid,
    input  logic [5:0]  simf0_rd_wfid,
    input  logic [5:0]  simf1_rd_wfid,
    input  logic [5:0]  simf2_rd_wfid,
    input  logic [5:0]  simf3_rd_wfid,
    input  logic        simd0_vcc_wr_en,
    input  logic        simd1_vcc_wr_en,
    input  logic        simd2_vcc_wr_en,
    input  logic        simd3_vcc_wr_en,
    input  logic        simf0_vcc_wr_en,
    input  logic        simf1_vcc_wr_en,
    input  logic        simf2_vcc_wr_en,
    input  logic        simf3_vcc_wr_en,
    input  logic [5:0]  simd0_vcc_wr_wfid,
    input  logic [5:0]  simd1_vcc_wr_wfid,
    input  logic [5:0]  simd2_vcc_wr_wfid,
    input  logic [5:0]  simd3_vcc_wr_wfid,
    input  logic [5:0]  simf0_vcc_wr_wfid,
    input  logic [5:0]  simf1_vcc_wr_wfid,
    input  logic [5:0]  simf2_vcc_wr_wfid,
    input  logic [5:0]  simf3_vcc_wr_wfid,
    input  logic [63:0] simd0_vcc_value,
    input  logic [63:0] simd1_vcc_value,
    input  logic [63:0] simd2_vcc_value,
    input  logic [63:0] simd3_vcc_value,
    input  logic [63:0] simf0_vcc_value,
    input  logic [63:0] simf1_vcc_value,
    input  logic [63:0] simf2_vcc_value,
    input  logic [63:0] simf3_vcc_value,
    input  logic [15:0] rfa_select_fu,
    input  logic [5:0]  lsu_rd_wfid,
    output logic [63:0] lsu_exec_value,
    output logic [31:0] lsu_rd_m0_value,
    output logic [63:0] simd_rd_exec_value,
    output logic [63:0] simd_rd_vcc_value,
    output logic [31:0] simd_rd_m0_value,
    output logic        simd_rd_scc_value,
    output logic [63:0] simf_rd_exec_value,
    output logic [63:0] simf_rd_vcc_value,
    output logic [31:0] simf_rd_m0_value,
    output logic        simf_rd_scc_value,
    output logic [63:0] salu_rd_exec_value,
    output logic [63:0] salu_rd_vcc_value,
    output logic [31:0] salu_rd_m0_value,
    output logic        salu_rd_scc_value,
    output logic        issue_salu_wr_exec_en,
    output logic        issue_salu_wr_vcc_en,
    output logic        issue_salu_wr_m0_en,
    output logic        issue_salu_wr_scc_en,
    output logic [5:0]  issue_salu_wr_vcc_wfid,
    output logic        issue_valu_wr_vcc_en,
    output logic [5:0]  issue_valu_wr_vcc_wfid
);

    logic [63:0] exec_mem [64];
    logic [63:0] vcc_mem  [64];
    logic [31:0] m0_mem   [64];
    logic        scc_mem  [64];

    // Vector units gathered into index order matching rfa_select_fu[7:0]
    logic [7:0]  valu_en;
    logic [5:0]  valu_wfid  [8];
    logic [63:0] valu_value [8];

    assign valu_en = {simf3_vcc_wr_en, simf2_vcc_wr_en, simf1_vcc_wr_en, simf0_vcc_wr_en,
                      simd3_vcc_wr_en, simd2_vcc_wr_en, simd1_vcc_wr_en, simd0_vcc_wr_en};
    assign valu_wfid[0] = simd0_vcc_wr_wfid;
    assign valu_wfid[1] = simd1_vcc_wr_wfid;
    assign valu_wfid[2] = simd2_vcc_wr_wfid;
    assign valu_wfid[3] = simd3_vcc_wr_wfid;
    assign valu_wfid[4] = simf0_vcc_wr_wfid;
    assign valu_wfid[5] = simf1_vcc_wr_wfid;
    assign valu_wfid[6] = simf2_vcc_wr_wfid;
    assign valu_wfid[7] = simf3_vcc_wr_wfid;
    assign valu_value[0] = simd0_vcc_value;
    assign valu_value[1] = simd1_vcc_value;
    assign valu_value[2] = simd2_vcc_value;
    assign valu_value[3] = simd3_vcc_value;
    assign valu_value[4] = simf0_vcc_value;
    assign valu_value[5] = simf1_vcc_value;
    assign valu_value[6] = simf2_vcc_value;
    assign valu_value[7] = simf3_vcc_value;

    logic [7:0]  grant;
    logic        grant_onehot;
    logic        valu_wr;
    logic [5:0]  valu_wr_wfid;
    logic [63:0] valu_wr_value;

    assign grant        = rfa_select_fu[7:0];
    assign grant_onehot = (grant != 8'd0) && ((grant & (grant - 8'd1)) == 8'd0);

    // Resolve the granted unit; a malformed grant vector yields no write
    always_comb begin
        valu_wr       = 1'b0;
        valu_wr_wfid  = 6'd0;
        valu_wr_value = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (grant_onehot && grant[i]) begin
                valu_wr       = valu_en[i];
                valu_wr_wfid  = valu_wfid[i];
                valu_wr_value = valu_value[i];
            end
        end
    end

    // State update; later assignments win, giving fetch > SALU > VALU per field
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                exec_mem[i] <= 64'd0;
                vcc_mem[i]  <= 64'd0;
                m0_mem[i]   <= 32'd0;
                scc_mem[i]  <= 1'b0;
            end
        end else begin
            if (valu_wr)
                vcc_mem[valu_wr_wfid] <= valu_wr_value;
            if (salu_wr_exec_en)
                exec_mem[salu_wr_wfid] <= salu_wr_exec_value;
            if (salu_wr_vcc_en)
                vcc_mem[salu_wr_wfid] <= salu_wr_vcc_value;
            if (salu_wr_m0_en)
                m0_mem[salu_wr_wfid] <= salu_wr_m0_value;
            if (salu_wr_scc_en)
                scc_mem[salu_wr_wfid] <= salu_wr_scc_value;
            if (fetch_init_wf_en) begin
                exec_mem[fetch_init_wf_id] <= fetch_init_value;
                vcc_mem[fetch_init_wf_id]  <= 64'd0;
                m0_mem[fetch_init_wf_id]   <= 32'd0;
                scc_mem[fetch_init_wf_id]  <= 1'b0;
            end
        end
    end

    // Issue notifications mirror the writes presented last cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_salu_wr_exec_en  <= 1'b0;
            issue_salu_wr_vcc_en   <= 1'b0;
            issue_salu_wr_m0_en    <= 1'b0;
            issue_salu_wr_scc_en   <= 1'b0;
            issue_salu_wr_vcc_wfid <= 6'd0;
            issue_valu_wr_vcc_en   <= 1'b0;
            issue_valu_wr_vcc_wfid <= 6'd0;
        end else begin
            issue_salu_wr_exec_en  <= salu_wr_exec_en;
            issue_salu_wr_vcc_en   <= salu_wr_vcc_en;
            issue_salu_wr_m0_en    <= salu_wr_m0_en;
            issue_salu_wr_scc_en   <= salu_wr_scc_en;
            issue_salu_wr_vcc_wfid <= salu_wr_wfid;
            issue_valu_wr_vcc_en   <= valu_wr;
            issue_valu_wr_vcc_wfid <= valu_wr ? valu_wr_wfid : 6'd0;
        end
    end

    // LSU read port is always live
    always_comb begin
        lsu_exec_value  = exec_mem[lsu_rd_wfid];
        lsu_rd_m0_value = m0_mem[lsu_rd_wfid];
    end

    // SIMD group read: lowest-numbered enabled unit picks the wavefront
    always_comb begin
        logic [5:0] id;
        logic       en;
        en = 1'b1;
        if (simd0_rd_en)      id = simd0_rd_wfid;
        else if (simd1_rd_en) id = simd1_rd_wfid;
        else if (simd2_rd_en) id = simd2_rd_wfid;
        else if (simd3_rd_en) id = simd3_rd_wfid;
        else begin
            id = 6'd0;
            en = 1'b0;
        end
        simd_rd_exec_value = en ? exec_mem[id] : 64'd0;
        simd_rd_vcc_value  = en ? vcc_mem[id]  : 64'd0;
        simd_rd_m0_value   = en ? m0_mem[id]   : 32'd0;
        simd_rd_scc_value  = en ? scc_mem[id]  : 1'b0;
    end

    // SIMF group read: same priority scheme as SIMD
    always_comb begin
        logic [5:0] id;
        logic       en;
        en = 1'b1;
        if (simf0_rd_en)      id = simf0_rd_wfid;
        else if (simf1_rd_en) id = simf1_rd_wfid;
        else if (simf2_rd_en) id = simf2_rd_wfid;
        else if (simf3_rd_en) id = simf3_rd_wfid;
        else begin
            id = 6'd0;
            en = 1'b0;
        end
        simf_rd_exec_value = en ? exec_mem[id] : 64'd0;
        simf_rd_vcc_value  = en ? vcc_mem[id]  : 64'd0;
        simf_rd_m0_value   = en ? m0_mem[id]   : 32'd0;
        simf_rd_scc_value  = en ? scc_mem[id]  : 1'b0;
    end

    // SALU read, gated by its enable
    always_comb begin
        salu_rd_exec_value = salu_rd_en ? exec_mem[salu_rd_wfid] : 64'd0;
        salu_rd_vcc_value  = salu_rd_en ? vcc_mem[salu_rd_wfid]  : 64'd0;
        salu_rd_m0_value   = salu_rd_en ? m0_mem[salu_rd_wfid]   : 32'd0;
        salu_rd_scc_value  = salu_rd_en ? scc_mem[salu_rd_wfid]  : 1'b0;
    end

endmodule

// File: tb/tb_exec_reg_file.sv
// tb/tb_exec_reg_file.sv - directed self-checking bench for exec_reg_file
module tb_exec_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_init_wf_en;
    logic [5:0]  fetch_init_wf_id;
    logic [63:0] fetch_init_value;
    logic        salu_wr_exec_en, salu_wr_vcc_en, salu_wr_m0_en, salu_wr_scc_en;
    logic [5:0]  salu_wr_wfid;
    logic [63:0] salu_wr_exec_value, salu_wr_vcc_value;
    logic [31:0] salu_wr_m0_value;
    logic        salu_wr_scc_value;
    logic        salu_rd_en;
    logic [5:0]  salu_rd_wfid;
    logic        simd0_rd_en, simd1_rd_en, simd2_rd_en, simd3_rd_en;
    logic        simf0_rd_en, simf1_rd_en, simf2_rd_en, simf3_rd_en;
    logic [5:0]  simd0_rd_wfid, simd1_rd_wfid, simd2_rd_wfid, simd3_rd_wfid;
    logic [5:0]  simf0_rd_wfid, simf1_rd_wfid, simf2_rd_wfid, simf3_rd_wfid;
    logic        simd0_vcc_wr_en, simd1_vcc_wr_en, simd2_vcc_wr_en, simd3_vcc_wr_en;
    logic        simf0_vcc_wr_en, simf1_vcc_wr_en, simf2_vcc_wr_en, simf3_vcc_wr_en;
    logic [5:0]  simd0_vcc_wr_wfid, simd1_vcc_wr_wfid, simd2_vcc_wr_wfid, simd3_vcc_wr_wfid;
    logic [5:0]  simf0_vcc_wr_wfid, simf1_vcc_wr_wfid, simf2_vcc_wr_wfid, simf3_vcc_wr_wfid;
    logic [63:0] simd0_vcc_value, simd1_vcc_value, simd2_vcc_value, simd3_vcc_value;
    logic [63:0] simf0_vcc_value, simf1_vcc_value, simf2_vcc_value, simf3_vcc_value;
    logic [15:0] rfa_select_fu;
    logic [5:0]  lsu_rd_wfid;
    logic [63:0] lsu_exec_value;
    logic [31:0] lsu_rd_m0_value;
    logic [63:0] simd_rd_exec_value, simd_rd_vcc_value;
    logic [31:0] simd_rd_m0_value;
    logic        simd_rd_scc_value;
    logic [63:0] simf_rd_exec_value, simf_rd_vcc_value;
    logic [31:0] simf_rd_m0_value;
    logic        simf_rd_scc_value;
    logic [63:0] salu_rd_exec_value, salu_rd_vcc_value;
    logic [31:0] salu_rd_m0_value;
    logic        salu_rd_scc_value;
    logic        issue_salu_wr_exec_en, issue_salu_wr_vcc_en, issue_salu_wr_m0_en, issue_salu_wr_scc_en;
    logic [5:0]  issue_salu_wr_vcc_wfid;
    logic        issue_valu_wr_vcc_en;
    logic [5:0]  issue_valu_wr_vcc_wfid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exec_reg_file dut (
        .clk(clk), .rst(rst),
        .fetch_init_wf_en(fetch_init_wf_en), .fetch_init_wf_id(fetch_init_wf_id),
        .fetch_init_value(fetch_init_value),
        .salu_wr_exec_en(salu_wr_exec_en), .salu_wr_vcc_en(salu_wr_vcc_en),
        .salu_wr_m0_en(salu_wr_m0_en), .salu_wr_scc_en(salu_wr_scc_en),
        .salu_wr_wfid(salu_wr_wfid),
        .salu_wr_exec_value(salu_wr_exec_value), .salu_wr_vcc_value(salu_wr_vcc_value),
        .salu_wr_m0_value(salu_wr_m0_value), .salu_wr_scc_value(salu_wr_scc_value),
        .salu_rd_en(salu_rd_en), .salu_rd_wfid(salu_rd_wfid),
        .simd0_rd_en(simd0_rd_en), .simd1_rd_en(simd1_rd_en),
        .simd2_rd_en(simd2_rd_en), .simd3_rd_en(simd3_rd_en),
        .simf0_rd_en(simf0_rd_en), .simf1_rd_en(simf1_rd_en),
        .simf2_rd_en(simf2_rd_en), .simf3_rd_en(simf3_rd_en),
        .simd0_rd_wfid(simd0_rd_wfid), .simd1_rd_wfid(simd1_rd_wfid),
        .simd2_rd_wfid(simd2_rd_wfid), .simd3_rd_wfid(simd3_rd_wfid),
        .simf0_rd_wfid(simf0_rd_wfid), .simf1_rd_wfid(simf1_rd_wfid),
        .simf2_rd_wfid(simf2_rd_wfid), .simf3_rd_wfid(simf3_rd_wfid),
        .simd0_vcc_wr_en(simd0_vcc_wr_en), .simd1_vcc_wr_en(simd1_vcc_wr_en),
        .simd2_vcc_wr_en(simd2_vcc_wr_en), .simd3_vcc_wr_en(simd3_vcc_wr_en),
        .simf0_vcc_wr_en(simf0_vcc_wr_en), .simf1_vcc_wr_en(simf1_vcc_wr_en),
        .simf2_vcc_wr_en(simf2_vcc_wr_en), .simf3_vcc_wr_en(simf3_vcc_wr_en),
        .simd0_vcc_wr_wfid(simd0_vcc_wr_wfid), .simd1_vcc_wr_wfid(simd1_vcc_wr_wfid),
        .simd2_vcc_wr_wfid(simd2_vcc_wr_wfid), .simd3_vcc_wr_wfid(simd3_vcc_wr_wfid),
        .simf0_vcc_wr_wfid(simf0_vcc_wr_wfid), .simf1_vcc_wr_wfid(simf1_vcc_wr_wfid),
        .simf2_vcc_wr_wfid(simf2_vcc_wr_wfid), .simf3_vcc_wr_wfid(simf3_vcc_wr_wfid),
        .simd0_vcc_value(simd0_vcc_value), .simd1_vcc_value(simd1_vcc_value),
        .simd2_vcc_value(simd2_vcc_value), .simd3_vcc_value(simd3_vcc_value),
        .simf0_vcc_value(simf0_vcc_value), .simf1_vcc_value(simf1_vcc_value),
        .simf2_vcc_value(simf2_vcc_value), .simf3_vcc_value(simf3_vcc_value),
        .rfa_select_fu(rfa_select_fu), .lsu_rd_wfid(lsu_rd_wfid),
        .lsu_exec_value(lsu_exec_value), .lsu_rd_m0_value(lsu_rd_m0_value),
        .simd_rd_exec_value(simd_rd_exec_value), .simd_rd_vcc_value(simd_rd_vcc_value),
        .simd_rd_m0_value(simd_rd_m0_value), .simd_rd_scc_value(simd_rd_scc_value),
        .simf_rd_exec_value(simf_rd_exec_value), .simf_rd_vcc_value(simf_rd_vcc_value),
        .simf_rd_m0_value(simf_rd_m0_value), .simf_rd_scc_value(simf_rd_scc_value),
        .salu_rd_exec_value(salu_rd_exec_value), .salu_rd_vcc_value(salu_rd_vcc_value),
        .salu_rd_m0_value(salu_rd_m0_value), .salu_rd_scc_value(salu_rd_scc_value),
        .issue_salu_wr_exec_en(issue_salu_wr_exec_en), .issue_salu_wr_vcc_en(issue_salu_wr_vcc_en),
        .issue_salu_wr_m0_en(issue_salu_wr_m0_en), .issue_salu_wr_scc_en(issue_salu_wr_scc_en),
        .issue_salu_wr_vcc_wfid(issue_salu_wr_vcc_wfid),
        .issue_valu_wr_vcc_en(issue_valu_wr_vcc_en), .issue_valu_wr_vcc_wfid(issue_valu_wr_vcc_wfid)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_init_wf_en = 0; fetch_init_wf_id = 0; fetch_init_value = 0;
        salu_wr_exec_en = 0; salu_wr_vcc_en = 0; salu_wr_m0_en = 0; salu_wr_scc_en = 0;
        salu_wr_wfid = 0; salu_wr_exec_value = 0; salu_wr_vcc_value = 0;
        salu_wr_m0_value = 0; salu_wr_scc_value = 0;
        simd0_vcc_wr_en = 0; simd1_vcc_wr_en = 0; simd2_vcc_wr_en = 0; simd3_vcc_wr_en = 0;
        simf0_vcc_wr_en = 0; simf1_vcc_wr_en = 0; simf2_vcc_wr_en = 0; simf3_vcc_wr_en = 0;
        simd0_vcc_wr_wfid = 0; simd1_vcc_wr_wfid = 0; simd2_vcc_wr_wfid = 0; simd3_vcc_wr_wfid = 0;
        simf0_vcc_wr_wfid = 0; simf1_vcc_wr_wfid = 0; simf2_vcc_wr_wfid = 0; simf3_vcc_wr_wfid = 0;
        simd0_vcc_value = 0; simd1_vcc_value = 0; simd2_vcc_value = 0; simd3_vcc_value = 0;
        simf0_vcc_value = 0; simf1_vcc_value = 0; simf2_vcc_value = 0; simf3_vcc_value = 0;
        rfa_select_fu = 0;
    endtask

    task automatic no_reads();
        salu_rd_en = 0; salu_rd_wfid = 0; lsu_rd_wfid = 0;
        simd0_rd_en = 0; simd1_rd_en = 0; simd2_rd_en = 0; simd3_rd_en = 0;
        simf0_rd_en = 0; simf1_rd_en = 0; simf2_rd_en = 0; simf3_rd_en = 0;
        simd0_rd_wfid = 0; simd1_rd_wfid = 0; simd2_rd_wfid = 0; simd3_rd_wfid = 0;
        simf0_rd_wfid = 0; simf1_rd_wfid = 0; simf2_rd_wfid = 0; simf3_rd_wfid = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        no_reads();
        tick();
        tick();
        rst = 0;
        tick();

        // Reset state
        salu_rd_en = 1; salu_rd_wfid = 6'd2; lsu_rd_wfid = 6'd2;
        #1;
        chk("rst_lsu_exec", lsu_exec_value, 64'h0);
        chk("rst_salu_vcc", salu_rd_vcc_value, 64'h0);
        chk("rst_issue_salu_exec", issue_salu_wr_exec_en, 1'b0);
        chk("rst_issue_valu", issue_valu_wr_vcc_en, 1'b0);
        no_reads();

        // Fetch init of wf 2; same-cycle read sees the old value
        fetch_init_wf_en = 1; fetch_init_wf_id = 6'd2; fetch_init_value = 64'h2D;
        lsu_rd_wfid = 6'd2;
        #1;
        chk("same_cycle_lsu_old", lsu_exec_value, 64'h0);
        tick();
        idle_inputs();
        simd0_rd_en = 1; simd0_rd_wfid = 6'd2;
        simd1_rd_en = 1; simd1_rd_wfid = 6'd7;
        #1;
        chk("init_simd_exec", simd_rd_exec_value, 64'h2D);
        chk("init_lsu_exec", lsu_exec_value, 64'h2D);
        chk("init_simd_vcc", simd_rd_vcc_value, 64'h0);
        chk("init_simd_m0", simd_rd_m0_value, 64'h0);
        chk("init_simd_scc", simd_rd_scc_value, 1'b0);
        chk("init_simf_exec_off", simf_rd_exec_value, 64'h0);
        no_reads();

        // SIMF2 read with SIMD disabled; lower-priority SIMF3 ignored
        simf2_rd_en = 1; simf2_rd_wfid = 6'd2;
        simf3_rd_en = 1; simf3_rd_wfid = 6'd9;
        #1;
        chk("simf2_exec", simf_rd_exec_value, 64'h2D);
        chk("simf2_simd_off", simd_rd_exec_value, 64'h0);

        // SALU write of all four fields
        salu_wr_exec_en = 1; salu_wr_vcc_en = 1; salu_wr_m0_en = 1; salu_wr_scc_en = 1;
        salu_wr_wfid = 6'd2; salu_wr_exec_value = 64'h09; salu_wr_vcc_value = 64'h1B;
        salu_wr_m0_value = 32'h0D; salu_wr_scc_value = 1'b1;
        tick();
        idle_inputs();
        #1;
        chk("salu_issue_exec", issue_salu_wr_exec_en, 1'b1);
        chk("salu_issue_vcc", issue_salu_wr_vcc_en, 1'b1);
        chk("salu_issue_m0", issue_salu_wr_m0_en, 1'b1);
        chk("salu_issue_scc", issue_salu_wr_scc_en, 1'b1);
        chk("salu_issue_wfid", issue_salu_wr_vcc_wfid, 6'd2);
        chk("salu_simf_exec", simf_rd_exec_value, 64'h09);
        chk("salu_simf_vcc", simf_rd_vcc_value, 64'h1B);
        chk("salu_simf_m0", simf_rd_m0_value, 64'h0D);
        chk("salu_simf_scc", simf_rd_scc_value, 1'b1);
        no_reads();

        // Granted SIMD1 VCC write, then SALU read
        rfa_select_fu = 16'h0002;
        simd1_vcc_wr_en = 1; simd1_vcc_wr_wfid = 6'd2; simd1_vcc_value = 64'h05;
        tick();
        idle_inputs();
        salu_rd_en = 1; salu_rd_wfid = 6'd2;
        #1;
        chk("valu_issue_en", issue_valu_wr_vcc_en, 1'b1);
        chk("valu_issue_wfid", issue_valu_wr_vcc_wfid, 6'd2);
        chk("valu_salu_issue_clear", issue_salu_wr_exec_en, 1'b0);
        chk("valu_rd_exec", salu_rd_exec_value, 64'h09);
        chk("valu_rd_vcc", salu_rd_vcc_value, 64'h05);
        chk("valu_rd_m0", salu_rd_m0_value, 64'h0D);
        chk("valu_rd_scc", salu_rd_scc_value, 1'b1);

        // Ungranted SIMF3 write is dropped
        rfa_select_fu = 16'h0001;
        simf3_vcc_wr_en = 1; simf3_vcc_wr_wfid = 6'd2; simf3_vcc_value = 64'h77;
        tick();
        idle_inputs();
        #1;
        chk("ungrant_issue_en", issue_valu_wr_vcc_en, 1'b0);
        chk("ungrant_vcc", salu_rd_vcc_value, 64'h05);

        // Two grant bits set: no write
        rfa_select_fu = 16'h0003;
        simd0_vcc_wr_en = 1; simd0_vcc_wr_wfid = 6'd2; simd0_vcc_value = 64'h66;
        tick();
        idle_inputs();
        #1;
        chk("multigrant_issue_en", issue_valu_wr_vcc_en, 1'b0);
        chk("multigrant_vcc", salu_rd_vcc_value, 64'h05);

        // SALU VCC beats granted SIMD0 VCC; overridden write still reported
        rfa_select_fu = 16'h0001;
        simd0_vcc_wr_en = 1; simd0_vcc_wr_wfid = 6'd2; simd0_vcc_value = 64'h55;
        salu_wr_vcc_en = 1; salu_wr_wfid = 6'd2; salu_wr_vcc_value = 64'hAA;
        tick();
        idle_inputs();
        #1;
        chk("conflict_vcc", salu_rd_vcc_value, 64'hAA);
        chk("conflict_issue_valu", issue_valu_wr_vcc_en, 1'b1);
        chk("conflict_issue_salu_vcc", issue_salu_wr_vcc_en, 1'b1);

        // SALU M0 merges with VALU VCC; upper grant bits ignored; other entry unaffected
        rfa_select_fu = 16'hFF10;
        simf0_vcc_wr_en = 1; simf0_vcc_wr_wfid = 6'd2; simf0_vcc_value = 64'h33;
        salu_wr_m0_en = 1; salu_wr_wfid = 6'd2; salu_wr_m0_value = 32'h44;
        tick();
        idle_inputs();
        lsu_rd_wfid = 6'd5;
        #1;
        chk("merge_vcc", salu_rd_vcc_value, 64'h33);
        chk("merge_m0", salu_rd_m0_value, 64'h44);
        chk("merge_other_entry", lsu_exec_value, 64'h0);

        // Fetch init overrides SALU EXEC and VALU VCC to the same entry
        fetch_init_wf_en = 1; fetch_init_wf_id = 6'd2; fetch_init_value = 64'hF0;
        salu_wr_exec_en = 1; salu_wr_wfid = 6'd2; salu_wr_exec_value = 64'h99;
        rfa_select_fu = 16'h0008;
        simd3_vcc_wr_en = 1; simd3_vcc_wr_wfid = 6'd2; simd3_vcc_value = 64'h11;
        tick();
        idle_inputs();
        #1;
        chk("fetch_over_exec", salu_rd_exec_value, 64'hF0);
        chk("fetch_over_vcc", salu_rd_vcc_value, 64'h0);
        chk("fetch_over_m0", salu_rd_m0_value, 64'h0);
        chk("fetch_over_issue_salu", issue_salu_wr_exec_en, 1'b1);

        // Mid-operation reset clears state and notifications at once
        lsu_rd_wfid = 6'd2;
        rst = 1;
        #1;
        chk("midrst_salu_exec", salu_rd_exec_value, 64'h0);
        chk("midrst_lsu_exec", lsu_exec_value, 64'h0);
        chk("midrst_issue_salu", issue_salu_wr_exec_en, 1'b0);
        chk("midrst_issue_valu", issue_valu_wr_vcc_en, 1'b0);

        // Write presented during reset is lost
        salu_wr_m0_en = 1; salu_wr_wfid = 6'd2; salu_wr_m0_value = 32'h12;
        tick();
        idle_inputs();
        rst = 0;
        tick();
        chk("rst_write_lost", salu_rd_m0_value, 64'h0);
        chk("rst_write_no_issue", issue_salu_wr_m0_en, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
